// File: rtl/rr_shared_reg_arbiter_pkg.sv
// Shared types and the wrap-around round-robin scan for rr_shared_reg_arbiter.
package rr_arb_pkg;

   localparam int unsigned REQ_MAX     = 16;
   localparam int unsigned IDX_MAX_W   = 4;
   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned ID_W        = $clog2(DEF_NUM_REQ);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic                 found;
      logic [IDX_MAX_W-1:0] idx;
   } rr_pick_t;

   // First eligible request after last_owner, wrapping modulo num_req; last_owner is scanned last.
   // Bits set in mask are excluded from the scan.
   function automatic rr_pick_t next_rr(input logic [REQ_MAX-1:0]   req,
                                        input logic [IDX_MAX_W-1:0] last_owner,
                                        input logic [REQ_MAX-1:0]   mask,
                                        input int unsigned          num_req);
      rr_pick_t             res;
      logic [REQ_MAX-1:0]   elig;
      logic [IDX_MAX_W-1:0] cand;
      res  = '0;
      elig = req & ~mask;
      for (int unsigned i = 1; i <= REQ_MAX; i++) begin
         cand = IDX_MAX_W'((32'(last_owner) + i) % num_req);
         if ((i <= num_req) && !res.found && elig[cand]) begin
            res.found = 1'b1;
            res.idx   = cand;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
interface rr_shared_reg_arbiter_if
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned DATA_W  = 8
);
   localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] wr_data;
   logic [NUM_REQ-1:0]        grant;
   logic [OWN_W-1:0]          owner_id;
   logic [DATA_W-1:0]         out;
   logic                      out_valid;

   modport master (
      output req, wr_data,
      input  grant, owner_id, out, out_valid
   );

   modport slave (
      input  req, wr_data,
      output grant, owner_id, out, out_valid
   );

endinterface

// File: rtl/rr_shared_reg_arbiter_pick.sv
// Combinational wrap-around priority scan (rr_priority_pick).
module rr_priority_pick
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned OWN_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWN_W-1:0]   last_owner,
   input  logic [NUM_REQ-1:0] mask,
   output logic [OWN_W-1:0]   pick_c,
   output logic               found_c
);

   rr_pick_t res_c;
   logic     unused_idx_c;

   // Scan req above last_owner, skipping masked bits.
   always_comb begin
      res_c = next_rr(REQ_MAX'(req), IDX_MAX_W'(last_owner), REQ_MAX'(mask), NUM_REQ);
   end

   assign pick_c       = OWN_W'(res_c.idx);
   assign found_c      = res_c.found;
   assign unused_idx_c = ^res_c.idx;

endmodule

// File: rtl/rr_shared_reg_arbiter.sv
// Round-robin arbiter time-sharing one registered DATA_W output among NUM_REQ requesters.
// Optional macro RR_ARB_HOLD_LIMIT_EN: force rotation after MAX_HOLD grant cycles while others wait.
module rr_shared_reg_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                    clock,
   input  logic                    reset_n,
   rr_shared_reg_arbiter_if.slave  bus
);

   localparam int unsigned OWN_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned HOLD_W = 8;

   // Reject configurations outside the supported range at elaboration.
   if ((NUM_REQ < 2) || (NUM_REQ > REQ_MAX) || (MAX_HOLD < 1) || (MAX_HOLD > 255) || (DATA_W < 1))
   begin : g_bad_cfg
      $error("rr_shared_reg_arbiter: parameter out of range");
   end

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [OWN_W-1:0]   owner_q, owner_d;
   logic [OWN_W-1:0]   last_q,  last_d;
   logic [DATA_W-1:0]  out_q,   out_d;
   logic               valid_q, valid_d;
   logic [NUM_REQ-1:0] mask_c;
   logic [OWN_W-1:0]   pick_c;
   logic               found_c;
   logic               take_c;
`ifdef RR_ARB_HOLD_LIMIT_EN
   logic [HOLD_W-1:0]  hold_q,  hold_d;
`endif

   // While owned, the owner is excluded so release and rotation pick among the others.
   assign mask_c = (state_q == OWNED) ? (NUM_REQ'(1) << owner_q) : '0;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .OWN_W   (OWN_W)
   ) u_pick (
      .req        (bus.req),
      .last_owner (last_q),
      .mask       (mask_c),
      .pick_c     (pick_c),
      .found_c    (found_c)
   );

   // Next-state, grant, hold and shared-register load.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      last_d  = last_q;
      out_d   = out_q;
      valid_d = 1'b0;
      take_c  = 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_d  = hold_q;
`endif

      if (grant_q[owner_q] && bus.req[owner_q]) begin
         out_d   = bus.wr_data[32'(owner_q)*DATA_W +: DATA_W];
         valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            take_c = found_c;
         end
         OWNED: begin
            if (!bus.req[owner_q]) begin
               take_c = found_c;
               if (!found_c) begin
                  state_d = IDLE;
                  grant_d = '0;
`ifdef RR_ARB_HOLD_LIMIT_EN
                  hold_d  = '0;
`endif
               end
            end
`ifdef RR_ARB_HOLD_LIMIT_EN
            else if (hold_q == HOLD_W'(MAX_HOLD)) begin
               take_c = found_c;
            end
            else begin
               hold_d = hold_q + HOLD_W'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (take_c) begin
         state_d = OWNED;
         grant_d = NUM_REQ'(1) << pick_c;
         owner_d = pick_c;
         last_d  = pick_c;
`ifdef RR_ARB_HOLD_LIMIT_EN
         hold_d  = HOLD_W'(1);
`endif
      end
   end

   // State, grant and shared-register flops.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         last_q  <= OWN_W'(NUM_REQ - 1);
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

`ifdef RR_ARB_HOLD_LIMIT_EN
   // Consecutive-grant counter for forced rotation.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end
`endif

   assign bus.grant     = grant_q;
   assign bus.owner_id  = owner_q;
   assign bus.out       = out_q;
   assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// Self-checking bench for rr_shared_reg_arbiter against a behavioural round-robin model.
// Honours RR_ARB_HOLD_LIMIT_EN the same way the design does.
module tb_rr_shared_reg_arbiter;
   import rr_arb_pkg::*;

   localparam int unsigned NREQ = DEF_NUM_REQ;
   localparam int unsigned DW   = 8;
   localparam int unsigned MAXH = 4;
   localparam int unsigned VW   = NREQ + ID_W + DW + 1;

   logic clock;
   logic reset_n;
   int   n_chk;
   int   n_fail;

   // Behavioural model: owner index (-1 = nobody), last owner, hold count, output register.
   int            m_owner;
   int            m_last;
   int            m_hold;
   logic [DW-1:0] m_out;
   logic          m_valid;

   rr_shared_reg_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

   rr_shared_reg_arbiter #(
      .NUM_REQ  (NREQ),
      .DATA_W   (DW),
      .MAX_HOLD (MAXH)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int ref_pick(input logic [NREQ-1:0] r, input int excl);
      for (int i = 1; i <= int'(NREQ); i++) begin
         int c;
         c = (m_last + i) % int'(NREQ);
         if (r[ID_W'(c)] && (c != excl)) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_last  = int'(NREQ) - 1;
      m_hold  = 0;
      m_out   = '0;
      m_valid = 1'b0;
   endtask

   task automatic model_take(input int p);
      m_owner = p;
      m_last  = p;
      m_hold  = 1;
   endtask

   // One rising edge of the reference behaviour, using the inputs present at that edge.
   task automatic model_edge();
      int p;
      if ((m_owner >= 0) && bus.req[ID_W'(m_owner)]) begin
         m_out   = bus.wr_data[m_owner*int'(DW) +: DW];
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (m_owner < 0) begin
         p = ref_pick(bus.req, -1);
         if (p >= 0) model_take(p);
      end else if (!bus.req[ID_W'(m_owner)]) begin
         p = ref_pick(bus.req, m_owner);
         if (p >= 0) model_take(p);
         else begin
            m_owner = -1;
            m_hold  = 0;
         end
      end
`ifdef RR_ARB_HOLD_LIMIT_EN
      else if (m_hold == int'(MAXH)) begin
         p = ref_pick(bus.req, m_owner);
         if (p >= 0) model_take(p);
      end
`endif
      else if (m_hold < int'(MAXH)) begin
         m_hold = m_hold + 1;
      end
   endtask

   function automatic logic [VW-1:0] exp_vec();
      logic [NREQ-1:0] g;
      logic [ID_W-1:0] o;
      g = '0;
      o = '0;
      if (m_owner >= 0) begin
         g[ID_W'(m_owner)] = 1'b1;
         o = ID_W'(m_owner);
      end
      return {g, o, m_out, m_valid};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {bus.grant, ((bus.grant != '0) ? bus.owner_id : ID_W'(0)), bus.out, bus.out_valid};
   endfunction

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      bus.req = '0;
      reset_n = 1'b0;
      #2;
      model_reset();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      #3;
      n_chk++;
      if (dut_vec() !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", dut_vec(), {VW{1'b0}});
      end
      @(posedge clock);
      #1;
      model_reset();
      reset_n     = 1'b1;
      bus.req     = 4'b0001;
      bus.wr_data = 32'h44332211;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_pre cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_chk++;
      if ({bus.grant, bus.owner_id, bus.out, bus.out_valid} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %h want 0", {bus.grant, bus.owner_id, bus.out, bus.out_valid});
      end
      model_reset();
      #1;
      reset_n = 1'b1;
      step();
      n_chk++;
      if ((bus.grant !== 4'b0001) || (dut_vec() !== exp_vec())) begin
         n_fail++;
         $display("FAIL reset_regrant: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.req     = 4'b0100;
      bus.wr_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};
      for (int i = 0; i < 5; i++) begin
         step();
         n_chk++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL single cyc%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
         n_chk++;
         if ((bus.grant !== 4'b0100) || (bus.owner_id !== ID_W'(2)) ||
             ((i >= 1) && ((bus.out !== 8'hA5) || (bus.out_valid !== 1'b1))) ||
             ((i == 0) && (bus.out_valid !== 1'b0))) begin
            n_fail++;
            $display("FAIL single_fixed cyc%0d: got grant=%b id=%0d out=%h v=%b", i,
                     bus.grant, bus.owner_id, bus.out, bus.out_valid);
         end
      end
   endtask

   task automatic test_rotation();
      do_reset();
      bus.req     = '1;
      bus.wr_data = $urandom;
      for (int i = 0; i < int'(NREQ); i++) begin
         step();
         n_chk++;
         if ((dut_vec() !== exp_vec()) || (bus.grant !== (NREQ'(1) << i))) begin
            n_fail++;
            $display("FAIL rotation owner%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
         if (m_owner >= 0) bus.req[ID_W'(m_owner)] = 1'b0;
      end
      step();
      n_chk++;
      if ((dut_vec() !== exp_vec()) || (bus.grant !== '0)) begin
         n_fail++;
         $display("FAIL rotation_idle: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_hold();
      int exp_own;
      do_reset();
      bus.req     = 4'b0011;
      bus.wr_data = $urandom;
      for (int i = 0; i < 12; i++) begin
         step();
`ifdef RR_ARB_HOLD_LIMIT_EN
         exp_own = (i / int'(MAXH)) % 2;
`else
         exp_own = 0;
`endif
         n_chk++;
         if ((dut_vec() !== exp_vec()) || (bus.grant !== (NREQ'(1) << exp_own))) begin
            n_fail++;
            $display("FAIL hold cyc%0d: got %h want %h (owner %0d)", i, dut_vec(), exp_vec(), exp_own);
         end
      end
      bus.req[0] = 1'b0;
      step();
      n_chk++;
      if ((dut_vec() !== exp_vec()) || (bus.grant !== 4'b0010)) begin
         n_fail++;
         $display("FAIL hold_release: got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_wrap();
      logic [NREQ-1:0] req_seq  [5];
      logic [NREQ-1:0] want_seq [5];
      req_seq  = '{4'b1000, 4'b0000, 4'b1001, 4'b0000, 4'b0001};
      want_seq = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
      do_reset();
      bus.wr_data = $urandom;
      for (int i = 0; i < 5; i++) begin
         bus.req = req_seq[i];
         step();
         n_chk++;
         if ((dut_vec() !== exp_vec()) || (bus.grant !== want_seq[i])) begin
            n_fail++;
            $display("FAIL wrap step%0d: got %h want %h", i, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      bus.req = '0;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < int'(NREQ); b++) begin
            if ($urandom_range(0, 3) == 0) bus.req[ID_W'(b)] = ~bus.req[ID_W'(b)];
         end
         bus.wr_data = $urandom;
         if ($urandom_range(0, 99) == 0) begin
            reset_n = 1'b0;
            #1;
            n_chk++;
            if (dut_vec() !== '0) begin
               n_fail++;
               $display("FAIL random_reset cyc%0d: got %h want 0", i, dut_vec());
            end
            model_reset();
            reset_n = 1'b1;
         end
         step();
         n_chk++;
         if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %h want %h req=%b", i, dut_vec(), exp_vec(), bus.req);
         end
      end
   endtask

   initial begin
      n_chk       = 0;
      n_fail      = 0;
      reset_n     = 1'b0;
      bus.req     = '0;
      bus.wr_data = '0;
      model_reset();
      test_reset();
      test_single();
      test_rotation();
      test_hold();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
